// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and its consumer.
// First-word-fall-through read port; pushes into a full FIFO are dropped and flagged in a sticky overrun.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int unsigned    DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   level_q;
  logic              overrun_q;

  logic push;
  logic pop;
  logic drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LEVEL_FULL);

  // A simultaneous read frees the slot, so a write into a full FIFO is accepted when rd is high.
  assign push = wr & (~full | rd);
  assign pop  = rd & ~empty;
  assign drop = wr & full & ~rd;

  // NOTE: the storage array has no reset; pointers and level define validity, so
  // resetting the array would only add a wide reset fan-out with no functional effect.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      mem[wp] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;

      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase

      // Setting wins over clearing in the same cycle so a fresh drop is never lost.
      if (drop)         overrun_q <= 1'b1;
      else if (clr_ovr) overrun_q <= 1'b0;
    end
  end

  assign level   = level_q;
  assign overrun = overrun_q;
  assign r_data  = empty ? '0 : mem[rp];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr;
  logic [DATA_W-1:0] w_data;
  logic              rd;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overrun;
  logic              clr_ovr;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] q[$];
  bit                m_ovr;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .w_data  (w_data),
    .rd      (rd),
    .r_data  (r_data),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [DATA_W-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check({ctx, ".empty"},   32'(empty),   32'(q.size() == 0));
    check({ctx, ".full"},    32'(full),    32'(q.size() == DEPTH));
    check({ctx, ".level"},   32'(level),   32'(q.size()));
    check({ctx, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({ctx, ".r_data"},  32'(r_data),  32'(head));
  endtask

  // Called just after a falling edge: checks the current state, applies one
  // cycle of stimulus, updates the model at the rising edge.
  task automatic cycle(input string ctx, input bit w, input logic [DATA_W-1:0] d,
                       input bit r, input bit c, input bit rs);
    bit was_full;
    bit was_empty;
    check_outputs(ctx);
    wr = w; w_data = d; rd = r; clr_ovr = c; reset = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (r && !was_empty) void'(q.pop_front());
      if (w && (!was_full || r)) q.push_back(d);
      if (w && was_full && !r) m_ovr = 1'b1;
      else if (c)              m_ovr = 1'b0;
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_ovr = 1'b0; reset = 1'b0;
  endtask

  task automatic push(input string ctx, input logic [DATA_W-1:0] d);
    cycle(ctx, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string ctx);
    cycle(ctx, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    wr = 1'b0; w_data = '0; rd = 1'b0; clr_ovr = 1'b0; reset = 1'b1;
    m_ovr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cycle("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Single byte: 1-cycle write-to-read latency, then drain.
    push("a5_push", 8'hA5);
    check("a5_head", 32'(r_data), 32'h0000_00A5);
    check("a5_level", 32'(level), 32'd1);
    pop("a5_pop");
    check("a5_empty_after", 32'(empty), 32'd1);

    // Fill to full, drop one, drain in order.
    for (int i = 0; i < DEPTH; i++) push("fill", 8'(i));
    check("fill_full", 32'(full), 32'd1);
    push("drop_ff", 8'hFF);
    check("drop_ovr", 32'(overrun), 32'd1);
    check("drop_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(r_data), 32'(i));
      pop("drain");
    end
    check("drain_empty", 32'(empty), 32'd1);
    cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Full FIFO with simultaneous write and read: accepted, not dropped.
    for (int i = 0; i < DEPTH; i++) push("fill2", 8'(i));
    check("wr_rd_head", 32'(r_data), 32'h0);
    cycle("wr_rd_full", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("wr_rd_level", 32'(level), 32'(DEPTH));
    check("wr_rd_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) pop("drain2");
    check("wr_rd_last", 32'(r_data), 32'h5A);
    pop("drain2_last");

    // Pointer wrap with a shallow queue.
    for (int i = 0; i < 40; i++) begin
      cycle("wrap", 1'b1, 8'(8'h10 + i), (i >= 2), 1'b0, 1'b0);
      check("wrap_level_max", 32'(level <= 3), 32'd1);
    end
    for (int i = 0; i < 2; i++) pop("wrap_tail");
    check("wrap_empty", 32'(empty), 32'd1);

    // Overrun set beats clear in the same cycle.
    for (int i = 0; i < DEPTH; i++) push("fill3", 8'(8'h80 + i));
    push("ovr_set", 8'hEE);
    cycle("ovr_set_clr", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    check("ovr_priority", 32'(overrun), 32'd1);
    cycle("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Reset mid-stream with wr and rd asserted.
    cycle("pre_rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) push("load5", 8'(8'hC0 + i));
    push("ovr_pre", 8'h00);
    cycle("rst_mid", 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rdata", 32'(r_data), 32'd0);
    push("post_rst", 8'h3C);
    check("post_rst_head", 32'(r_data), 32'h3C);

    // Random traffic in phases with shifting push/pop bias.
    for (int phase = 0; phase < 4; phase++) begin
      int wp_pct;
      int rp_pct;
      wp_pct = (phase % 2 == 0) ? 75 : 30;
      rp_pct = (phase % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 600; i++) begin
        cycle("rand",
              ($urandom_range(99) < wp_pct),
              8'($urandom),
              ($urandom_range(99) < rp_pct),
              ($urandom_range(99) < 5),
              ($urandom_range(999) < 3));
      end
    end
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
